// File: rtl/csr_access_sequencer.sv
// Atomic read-modify-write sequencer for Zicsr instructions; stalls the pipeline and freezes counters while in flight.
// Optional access/illegal statistics counters are enabled by defining CSR_ACCESS_STATS_EN.
module csr_access_sequencer #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_src,
  input  logic              req_src_zero,
  output logic [ADDR_W-1:0] csr_rd_addr,
  input  logic [DATA_W-1:0] csr_rd_data,
  output logic              csr_we,
  output logic [ADDR_W-1:0] csr_wr_addr,
  output logic [DATA_W-1:0] csr_wr_data,
  output logic              cnt_hold,
  output logic              stall,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_illegal
`ifdef CSR_ACCESS_STATS_EN
  ,
  output logic [31:0]       stat_access,
  output logic [31:0]       stat_illegal
`endif
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [1:0] OP_RW = 2'b00;
  localparam logic [1:0] OP_RS = 2'b01;
  localparam logic [1:0] OP_RC = 2'b10;

  state_t            state, next_state;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] src_q, old_q, new_q;
  logic              src_zero_q, illegal_q;
  logic [DATA_W-1:0] new_val;
  logic              do_write, illegal;

  // Read-modify-write decision, evaluated against live read data in READ
  always_comb begin
    new_val  = req_src;
    do_write = 1'b0;
    new_val  = src_q;
    case (op_q)
      OP_RW: begin new_val = src_q;                do_write = 1'b1;        end
      OP_RS: begin new_val = csr_rd_data | src_q;  do_write = !src_zero_q; end
      OP_RC: begin new_val = csr_rd_data & ~src_q; do_write = !src_zero_q; end
      default: begin new_val = src_q;              do_write = 1'b0;        end
    endcase
    illegal = (op_q == 2'b11) || (do_write && (addr_q[ADDR_W-1 -: 2] == 2'b11));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (req_valid) next_state = READ;
      READ:  next_state = (illegal || !do_write) ? RESP : WRITE;
      WRITE: next_state = RESP;
      RESP:  if (resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q       <= '0;
      addr_q     <= '0;
      src_q      <= '0;
      src_zero_q <= 1'b0;
      old_q      <= '0;
      new_q      <= '0;
      illegal_q  <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        op_q       <= req_op;
        addr_q     <= req_addr;
        src_q      <= req_src;
        src_zero_q <= req_src_zero;
      end
      if (state == READ) begin
        old_q     <= csr_rd_data;
        new_q     <= new_val;
        illegal_q <= illegal;
      end
    end
  end

  // Outputs are gated by reset so the block looks quiescent while reset is held
  always_comb begin
    req_ready    = (state == IDLE);
    stall        = (state != IDLE) || (req_valid && !reset);
    cnt_hold     = (state == READ) || (state == WRITE);
    csr_rd_addr  = (state == IDLE) ? (reset ? '0 : req_addr) : addr_q;
    csr_we       = (state == WRITE);
    csr_wr_addr  = (state == WRITE) ? addr_q : '0;
    csr_wr_data  = (state == WRITE) ? new_q : '0;
    resp_valid   = (state == RESP);
    resp_illegal = (state == RESP) && illegal_q;
    resp_data    = ((state == RESP) && !illegal_q) ? old_q : '0;
  end

`ifdef CSR_ACCESS_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_access  <= '0;
      stat_illegal <= '0;
    end else if (resp_valid && resp_ready) begin
      stat_access <= stat_access + 32'd1;
      if (illegal_q) stat_illegal <= stat_illegal + 32'd1;
    end
  end
`endif

endmodule
